// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card bring-up sequencer: power-up clocks, CMD0, CMD55/ACMD41, CMD16,
// then single-block CMD17 reads on request. Drives the command executor one command at a time.
module sd_init_sequencer #(
    parameter int POWERUP_CYCLES = 80,
    parameter int CMD0_RETRIES   = 8,
    parameter int ACMD41_RETRIES = 255
) (
    input  logic        clk400,
    input  logic        reset,
    input  logic        readRequest,
    input  logic [22:0] blockNumber,
    input  logic        commandDone,
    input  logic [7:0]  response,
    output logic [5:0]  command,
    output logic [31:0] argument,
    output logic        startCommand,
    output logic        sdCS,
    output logic        initDone,
    output logic        initError,
    output logic        readDone,
    output logic        readError
);

    localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYCLES - 1);
    localparam logic [7:0] CMD0_LIMIT   = 8'(CMD0_RETRIES);
    localparam logic [7:0] ACMD41_LIMIT = 8'(ACMD41_RETRIES);

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD17  = 6'b010001;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD55  = 6'd55;

    localparam logic [7:0] R1_READY = 8'h00;
    localparam logic [7:0] R1_IDLE  = 8'h01;

    localparam logic [31:0] BLOCK_LEN = 32'h0000_0200;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_DONE,
        ST_READY,
        ST_ERROR
    } state_t;

    state_t        state;
    logic [PW-1:0] pwr_cnt;
    logic [7:0]    cmd0_cnt;
    logic [7:0]    acmd_cnt;

    always_ff @(posedge clk400) begin
        if (!reset) begin
            state        <= ST_POWERUP;
            pwr_cnt      <= '0;
            cmd0_cnt     <= '0;
            acmd_cnt     <= '0;
            command      <= '0;
            argument     <= '0;
            startCommand <= 1'b0;
            sdCS         <= 1'b1;
            initDone     <= 1'b0;
            initError    <= 1'b0;
            readDone     <= 1'b0;
            readError    <= 1'b0;
        end else begin
            startCommand <= 1'b0;
            readDone     <= 1'b0;
            readError    <= 1'b0;

            case (state)
                ST_POWERUP: begin
                    if (pwr_cnt == PWR_LAST) begin
                        sdCS         <= 1'b0;
                        cmd0_cnt     <= '0;
                        command      <= CMD0;
                        argument     <= '0;
                        startCommand <= 1'b1;
                        state        <= ST_ISSUE;
                    end else begin
                        pwr_cnt <= pwr_cnt + PW'(1);
                    end
                end

                // commandDone is still the executor's idle flag here; it must not be read yet.
                ST_ISSUE: state <= ST_WAIT_LOW;

                ST_WAIT_LOW: begin
                    if (!commandDone) state <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (commandDone) begin
                        case (command)
                            CMD0: begin
                                if (response == R1_IDLE) begin
                                    acmd_cnt     <= '0;
                                    command      <= CMD55;
                                    argument     <= '0;
                                    startCommand <= 1'b1;
                                    state        <= ST_ISSUE;
                                end else if (cmd0_cnt + 8'd1 == CMD0_LIMIT) begin
                                    initError <= 1'b1;
                                    state     <= ST_ERROR;
                                end else begin
                                    cmd0_cnt     <= cmd0_cnt + 8'd1;
                                    startCommand <= 1'b1;
                                    state        <= ST_ISSUE;
                                end
                            end
                            CMD55: begin
                                if (response == R1_IDLE || response == R1_READY) begin
                                    command      <= ACMD41;
                                    argument     <= '0;
                                    startCommand <= 1'b1;
                                    state        <= ST_ISSUE;
                                end else begin
                                    initError <= 1'b1;
                                    state     <= ST_ERROR;
                                end
                            end
                            ACMD41: begin
                                if (response == R1_READY) begin
                                    command      <= CMD16;
                                    argument     <= BLOCK_LEN;
                                    startCommand <= 1'b1;
                                    state        <= ST_ISSUE;
                                end else if (response == R1_IDLE &&
                                             acmd_cnt + 8'd1 != ACMD41_LIMIT) begin
                                    // Card still initialising: go round CMD55/ACMD41 again.
                                    acmd_cnt     <= acmd_cnt + 8'd1;
                                    command      <= CMD55;
                                    argument     <= '0;
                                    startCommand <= 1'b1;
                                    state        <= ST_ISSUE;
                                end else begin
                                    initError <= 1'b1;
                                    state     <= ST_ERROR;
                                end
                            end
                            CMD16: begin
                                if (response == R1_READY) begin
                                    initDone <= 1'b1;
                                    state    <= ST_READY;
                                end else begin
                                    initError <= 1'b1;
                                    state     <= ST_ERROR;
                                end
                            end
                            CMD17: begin
                                readDone  <= (response == R1_READY);
                                readError <= (response != R1_READY);
                                state     <= ST_READY;
                            end
                            default: begin
                                initError <= 1'b1;
                                state     <= ST_ERROR;
                            end
                        endcase
                    end
                end

                ST_READY: begin
                    if (readRequest) begin
                        command      <= CMD17;
                        argument     <= {blockNumber, 9'b0};
                        startCommand <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end

                ST_ERROR: state <= ST_ERROR;

                default: begin
                    initError <= 1'b1;
                    state     <= ST_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer with a behavioural command-executor model.
module tb_sd_init_sequencer;

    logic        clk;
    logic        reset;
    logic        readRequest;
    logic [22:0] blockNumber;
    logic        commandDone;
    logic [7:0]  response;
    logic [5:0]  command;
    logic [31:0] argument;
    logic        startCommand;
    logic        sdCS;
    logic        initDone;
    logic        initError;
    logic        readDone;
    logic        readError;

    int checks = 0;
    int errors = 0;

    sd_init_sequencer dut (
        .clk400       (clk),
        .reset        (reset),
        .readRequest  (readRequest),
        .blockNumber  (blockNumber),
        .commandDone  (commandDone),
        .response     (response),
        .command      (command),
        .argument     (argument),
        .startCommand (startCommand),
        .sdCS         (sdCS),
        .initDone     (initDone),
        .initError    (initError),
        .readDone     (readDone),
        .readError    (readError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Executor model state (written only by the model process).
    int          mode = 0;          // 0: well-behaved card, 1: CMD0 always 0xFF
    logic [7:0]  r17 = 8'h00;
    int          phase;
    int          busy;
    int          acmd_seen;
    int          log_n;
    int          log_cmd [64];
    logic [31:0] log_arg [64];
    int          start_cycles;
    int          rd_done_n;
    int          rd_err_n;
    int          last_done_cyc;
    logic [7:0]  pending;

    function automatic logic [7:0] reply(input logic [5:0] c);
        if (mode == 1 && c == 6'd0) return 8'hFF;
        case (c)
            6'd0:    return 8'h01;
            6'd55:   return 8'h01;
            6'd41:   return (acmd_seen < 3) ? 8'h01 : 8'h00;
            6'd16:   return 8'h00;
            6'd17:   return r17;
            default: return 8'hFF;
        endcase
    endfunction

    initial begin
        commandDone = 1'b1;
        response = 8'hFF;
        phase = 0; busy = 0; acmd_seen = 0; log_n = 0;
        start_cycles = 0; rd_done_n = 0; rd_err_n = 0; last_done_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                phase = 0; commandDone = 1'b1; acmd_seen = 0; log_n = 0;
                start_cycles = 0; rd_done_n = 0; rd_err_n = 0;
            end else begin
                if (startCommand === 1'b1) start_cycles++;
                if (readDone === 1'b1) rd_done_n++;
                if (readError === 1'b1) rd_err_n++;
                case (phase)
                    0: if (startCommand === 1'b1) begin
                        pending = reply(command);
                        if (command == 6'd41) acmd_seen++;
                        if (log_n < 64) begin
                            log_cmd[log_n] = int'(command);
                            log_arg[log_n] = argument;
                        end
                        log_n++;
                        busy = (command == 6'd17) ? 12 : 1;
                        phase = 1;
                    end
                    1: begin
                        commandDone = 1'b0;
                        phase = 2;
                    end
                    default: begin
                        if (busy > 1) busy--;
                        else begin
                            response = pending;
                            commandDone = 1'b1;
                            last_done_cyc = cyc;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_command"}, 32'(command), 32'd0);
        check({tag, "_argument"}, argument, 32'd0);
        check({tag, "_start"}, 32'(startCommand), 32'd0);
        check({tag, "_sdcs"}, 32'(sdCS), 32'd1);
        check({tag, "_initdone"}, 32'(initDone), 32'd0);
        check({tag, "_initerror"}, 32'(initError), 32'd0);
        check({tag, "_readdone"}, 32'(readDone), 32'd0);
        check({tag, "_readerror"}, 32'(readError), 32'd0);
    endtask

    task automatic do_reset();
        int n;
        reset = 1'b0;
        readRequest = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        n = 0;
        while (sdCS === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("powerup_cycles", n, 80);
        check("first_start", 32'(startCommand), 32'd1);
        check("first_command", 32'(command), 32'd0);
        check("first_argument", argument, 32'd0);
    endtask

    task automatic wait_init();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (initDone === 1'b1 || initError === 1'b1) break;
        end
    endtask

    task automatic check_init_log();
        int exp_cmds [10] = '{0, 55, 41, 55, 41, 55, 41, 55, 41, 16};
        check("init_done", 32'(initDone), 32'd1);
        check("init_error_clear", 32'(initError), 32'd0);
        check("init_done_latency", cyc - last_done_cyc, 32'd1);
        check("init_cmd_count", log_n, 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("init_cmd%0d", i), log_cmd[i], exp_cmds[i]);
        check("cmd16_argument", log_arg[9], 32'h0000_0200);
        check("start_once_per_cmd", start_cycles, log_n);
        check("sdcs_low", 32'(sdCS), 32'd0);
    endtask

    task automatic do_read(input logic [22:0] blk, input logic [7:0] r, input logic [31:0] exp_arg);
        blockNumber = blk;
        r17 = r;
        readRequest = 1'b1;
        @(negedge clk);
        readRequest = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (readDone === 1'b1 || readError === 1'b1) break;
        end
        repeat (5) @(negedge clk);
        check("read_command", log_cmd[(log_n > 0) ? (log_n - 1) % 64 : 0], 32'd17);
        check("read_argument", log_arg[(log_n > 0) ? (log_n - 1) % 64 : 0], exp_arg);
        check("read_ready_again", 32'(initDone), 32'd1);
    endtask

    initial begin
        int before_n;
        int n;
        reset = 1'b0;
        readRequest = 1'b0;
        blockNumber = '0;

        // Normal bring-up followed by reads.
        mode = 0;
        do_reset();
        wait_init();
        check_init_log();

        do_read(23'h000003, 8'h00, 32'h0000_0600);
        check("read1_done_pulses", rd_done_n, 32'd1);
        check("read1_err_pulses", rd_err_n, 32'd0);

        do_read(23'h7FFFFF, 8'h05, 32'hFFFF_FE00);
        check("read2_err_pulses", rd_err_n, 32'd1);
        check("read2_done_pulses", rd_done_n, 32'd1);

        // Held request re-triggers one read per completion.
        before_n = log_n;
        blockNumber = 23'h000010;
        r17 = 8'h00;
        readRequest = 1'b1;
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (readDone === 1'b1) n++;
            if (n == 2) break;
        end
        readRequest = 1'b0;
        repeat (100) @(negedge clk);
        check("held_read_count", log_n, before_n + 2);
        check("held_done_pulses", rd_done_n, 32'd3);
        check("held_start_once", start_cycles, log_n);
        check("held_arg", log_arg[(log_n - 1) % 64], 32'h0000_2000);

        // Reset during the ACMD41 wait, then a full restart.
        mode = 0;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (log_n >= 5 && log_cmd[4] == 41 && commandDone === 1'b0) break;
        end
        check("mid_reset_in_acmd41", log_cmd[4], 32'd41);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        do_reset();
        wait_init();
        check_init_log();

        // CMD0 never answers idle: exactly CMD0_RETRIES attempts then sticky error.
        mode = 1;
        do_reset();
        wait_init();
        check("cmd0_fail_error", 32'(initError), 32'd1);
        check("cmd0_fail_initdone", 32'(initDone), 32'd0);
        check("cmd0_fail_count", log_n, 32'd8);
        check("cmd0_fail_last_cmd", log_cmd[7], 32'd0);
        check("cmd0_fail_starts", start_cycles, 32'd8);
        readRequest = 1'b1;
        repeat (1000) @(negedge clk);
        readRequest = 1'b0;
        check("error_no_more_starts", start_cycles, 32'd8);
        check("error_sticky", 32'(initError), 32'd1);
        check("error_no_read", rd_done_n + rd_err_n, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
